// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixer slice.
package audio_pkg;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN
  } ramp_state_t;

  localparam int          GAIN_UNITY = 256;
  localparam logic [15:0] SAMPLE_MAX = 16'hFFFF;
  localparam int          NUM_CH     = 2;
  localparam int          GAIN_W     = 9;
  localparam int          SPK_W      = 14;

  function automatic logic [15:0] sat16(input logic [17:0] s);
    return (s > 18'(SAMPLE_MAX)) ? SAMPLE_MAX : s[15:0];
  endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// Source/sink bundle of the audio mixer; names are seen from the mixer side.
interface audio_mixer_if;
  logic        sample_stb_i;
  logic        sleep_i;
  logic [15:0] ssp_audio_i;
  logic [9:0]  mb_audio_l_i;
  logic [9:0]  mb_audio_r_i;
  logic        speaker_i;
  logic [15:0] core_l_o;
  logic [15:0] core_r_o;
  logic        valid_o;
  logic        muted_o;

  modport slave (
    input  sample_stb_i, sleep_i, ssp_audio_i, mb_audio_l_i, mb_audio_r_i, speaker_i,
    output core_l_o, core_r_o, valid_o, muted_o
  );

  modport master (
    output sample_stb_i, sleep_i, ssp_audio_i, mb_audio_l_i, mb_audio_r_i, speaker_i,
    input  core_l_o, core_r_o, valid_o, muted_o
  );
endinterface

// File: rtl/speaker_dc_decay.sv
// Apple speaker edge latch + idle counter + exponential DC decay of the speaker level.
module speaker_dc_decay
  import audio_pkg::*;
#(
  parameter int unsigned SPK_LEVEL        = 8192,
  parameter int unsigned SPK_IDLE_SAMPLES = 4410,
  parameter int unsigned SPK_DECAY_SHIFT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_stb_i,
  input  logic             speaker_i,
  output logic [SPK_W-1:0] spk_level_o   // level as it stands after this cycle's update
);
  localparam int unsigned           IDLE_W   = $clog2(SPK_IDLE_SAMPLES + 1);
  localparam logic [IDLE_W-1:0]     IDLE_MAX = IDLE_W'(SPK_IDLE_SAMPLES);

  logic              speaker_q;
  logic              chg;
  logic              toggled_q, toggled_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [SPK_W-1:0]  level_q, level_d, dec;

  always_comb begin
    chg       = speaker_i ^ speaker_q;
    toggled_d = toggled_q | chg;
    idle_d    = idle_q;
    level_d   = level_q;
    // Small levels would stall at a nonzero value; force a unit step.
    dec       = level_q >> SPK_DECAY_SHIFT;
    if (dec == '0 && level_q != '0) dec = SPK_W'(1);
    if (sample_stb_i) begin
      // A change seen on the strobe cycle itself is kept for the next strobe.
      toggled_d = chg;
      if (toggled_q) begin
        level_d = speaker_q ? SPK_W'(SPK_LEVEL) : '0;
        idle_d  = '0;
      end else if (idle_q < IDLE_MAX) begin
        idle_d = idle_q + 1'b1;
      end else begin
        level_d = level_q - dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speaker_q <= 1'b0;
      toggled_q <= 1'b0;
      idle_q    <= '0;
      level_q   <= '0;
    end else begin
      speaker_q <= speaker_i;
      toggled_q <= toggled_d;
      idle_q    <= idle_d;
      level_q   <= level_d;
    end
  end

  assign spk_level_o = level_d;

endmodule

// File: rtl/audio_mixer.sv
// Mixes PSG, Mockingboard and speaker per channel with saturation, then applies a sleep-driven gain ramp.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int unsigned SPK_LEVEL        = 8192,
  parameter int unsigned SPK_IDLE_SAMPLES = 4410,
  parameter int unsigned SPK_DECAY_SHIFT  = 4,
  parameter int unsigned RAMP_STEP        = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  audio_mixer_if.slave  bus
);
  localparam int STAGES = 2;

  logic                           stb;
  logic [STAGES:1]                vld_pipe_q;
  logic [SPK_W-1:0]               spk_level;
  ramp_state_t                    state_q, state_d;
  logic [GAIN_W-1:0]              gain_q, gain_d, gain_up, gain_dn;
  logic [GAIN_W:0]                up_w;
  logic                           muted_q;
  logic [NUM_CH-1:0][9:0]         mb;
  logic [NUM_CH-1:0][15:0]        sum_q;
  logic [NUM_CH-1:0][15:0]        out_q;

  assign stb   = bus.sample_stb_i;
  assign mb[0] = bus.mb_audio_l_i;
  assign mb[1] = bus.mb_audio_r_i;

  speaker_dc_decay #(
    .SPK_LEVEL        (SPK_LEVEL),
    .SPK_IDLE_SAMPLES (SPK_IDLE_SAMPLES),
    .SPK_DECAY_SHIFT  (SPK_DECAY_SHIFT)
  ) u_spk (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_stb_i (stb),
    .speaker_i    (bus.speaker_i),
    .spk_level_o  (spk_level)
  );

  // Gain ramp: clamped one-step moves; direction follows sleep_i every strobe.
  always_comb begin
    up_w    = {1'b0, gain_q} + (GAIN_W + 1)'(RAMP_STEP);
    gain_up = (up_w >= (GAIN_W + 1)'(GAIN_UNITY)) ? GAIN_W'(GAIN_UNITY) : up_w[GAIN_W-1:0];
    gain_dn = (gain_q <= GAIN_W'(RAMP_STEP)) ? '0 : gain_q - GAIN_W'(RAMP_STEP);
    state_d = state_q;
    gain_d  = gain_q;
    if (stb) begin
      case (state_q)
        MUTED: begin
          if (!bus.sleep_i) begin
            gain_d  = gain_up;
            state_d = (gain_up == GAIN_W'(GAIN_UNITY)) ? ACTIVE : RAMP_UP;
          end
        end
        ACTIVE: begin
          if (bus.sleep_i) begin
            gain_d  = gain_dn;
            state_d = (gain_dn == '0) ? MUTED : RAMP_DOWN;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (bus.sleep_i) begin
            gain_d  = gain_dn;
            state_d = (gain_dn == '0) ? MUTED : RAMP_DOWN;
          end else begin
            gain_d  = gain_up;
            state_d = (gain_up == GAIN_W'(GAIN_UNITY)) ? ACTIVE : RAMP_UP;
          end
        end
        default: state_d = MUTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MUTED;
      gain_q     <= '0;
      muted_q    <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], stb};
      if (stb) muted_q <= (gain_d == '0);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [17:0] sum;
    logic [24:0] prod;
    logic        unused_prod;

    // Stage 1 mixes in the speaker level updated by this same strobe.
    assign sum  = 18'(bus.ssp_audio_i) + 18'({mb[c], 5'b0}) + 18'(spk_level);
    assign prod = 25'(sum_q[c]) * 25'(gain_q);
    assign unused_prod = ^{prod[24], prod[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q[c] <= '0;
        out_q[c] <= '0;
      end else begin
        if (stb)           sum_q[c] <= sat16(sum);
        if (vld_pipe_q[1]) out_q[c] <= prod[23:8];
      end
    end
  end

  assign bus.core_l_o = out_q[0];
  assign bus.core_r_o = out_q[1];
  assign bus.valid_o  = vld_pipe_q[STAGES];
  assign bus.muted_o  = muted_q;

endmodule
